// File: rtl/serial_tx_hex_fmt.sv
// Formats 32-bit words as ASCII hex characters (MSB nibble first), optionally
// followed by CR LF, and hands them one at a time to the UART transmit FIFO.
module serial_tx_hex_fmt #(
  parameter int DIGITS = 8,
  parameter bit EOL_EN = 1'b1,
  parameter bit UPPER  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        I_STB,
  input  logic [31:0] I_DATA,
  output logic        I_ACK,
  output logic        O_STB,
  output logic [7:0]  O_DATA,
  input  logic        O_ACK,
  output logic        O_BUSY,
  output logic [1:0]  DBG_STATE
);

  // Handshakes: a transfer happens on a rising CLK edge where strobe and ack
  // are both high. I_ACK is only given in IDLE; O_STB/O_DATA hold until O_ACK.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEX  = 2'd1,
    CR   = 2'd2,
    LF   = 2'd3
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(DIGITS - 1);

  state_t      state;
  logic [31:0] word_q;
  logic [2:0]  cnt;
  logic        xfer;

  // 0x37 + n lands on 'A' for n=10, 0x57 + n lands on 'a'.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else if (UPPER)
      return 8'h37 + {4'h0, n};
    else
      return 8'h57 + {4'h0, n};
  endfunction

  function automatic logic [3:0] nibble(input logic [31:0] w, input logic [2:0] idx);
    logic [31:0] s;
    s = w >> {idx, 2'b00};
    return s[3:0];
  endfunction

  assign xfer      = O_STB && O_ACK;
  assign I_ACK     = (state == IDLE) && I_STB;
  assign DBG_STATE = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      word_q <= 32'h0;
      cnt    <= 3'd0;
      O_STB  <= 1'b0;
      O_DATA <= 8'h00;
      O_BUSY <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_STB) begin
            word_q <= I_DATA;
            cnt    <= CNT_INIT;
            O_STB  <= 1'b1;
            O_DATA <= hex_char(nibble(I_DATA, CNT_INIT));
            O_BUSY <= 1'b1;
            state  <= HEX;
          end
        end
        HEX: begin
          if (xfer) begin
            if (cnt != 3'd0) begin
              cnt    <= cnt - 3'd1;
              O_DATA <= hex_char(nibble(word_q, cnt - 3'd1));
            end else if (EOL_EN) begin
              O_DATA <= 8'h0D;
              state  <= CR;
            end else begin
              O_STB  <= 1'b0;
              O_BUSY <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        CR: begin
          if (xfer) begin
            O_DATA <= 8'h0A;
            state  <= LF;
          end
        end
        LF: begin
          if (xfer) begin
            O_STB  <= 1'b0;
            O_BUSY <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_hex_fmt.sv
// Directed bench for serial_tx_hex_fmt: default build, a 2-digit lowercase
// build without EOL, and a 1-digit build.
module tb_serial_tx_hex_fmt;

  logic clk;
  logic rst_n;

  // DUT A: defaults
  logic        a_i_stb, a_i_ack, a_o_stb, a_o_ack, a_o_busy;
  logic [31:0] a_i_data;
  logic [7:0]  a_o_data;
  logic [1:0]  a_state;
  // DUT B: DIGITS=2, EOL_EN=0, UPPER=0
  logic        b_i_stb, b_i_ack, b_o_stb, b_o_ack, b_o_busy;
  logic [31:0] b_i_data;
  logic [7:0]  b_o_data;
  logic [1:0]  b_state;
  // DUT C: DIGITS=1
  logic        c_i_stb, c_i_ack, c_o_stb, c_o_ack, c_o_busy;
  logic [31:0] c_i_data;
  logic [7:0]  c_o_data;
  logic [1:0]  c_state;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  serial_tx_hex_fmt u_a (
    .CLK(clk), .RST_N(rst_n), .I_STB(a_i_stb), .I_DATA(a_i_data), .I_ACK(a_i_ack),
    .O_STB(a_o_stb), .O_DATA(a_o_data), .O_ACK(a_o_ack), .O_BUSY(a_o_busy),
    .DBG_STATE(a_state)
  );

  serial_tx_hex_fmt #(.DIGITS(2), .EOL_EN(1'b0), .UPPER(1'b0)) u_b (
    .CLK(clk), .RST_N(rst_n), .I_STB(b_i_stb), .I_DATA(b_i_data), .I_ACK(b_i_ack),
    .O_STB(b_o_stb), .O_DATA(b_o_data), .O_ACK(b_o_ack), .O_BUSY(b_o_busy),
    .DBG_STATE(b_state)
  );

  serial_tx_hex_fmt #(.DIGITS(1)) u_c (
    .CLK(clk), .RST_N(rst_n), .I_STB(c_i_stb), .I_DATA(c_i_data), .I_ACK(c_i_ack),
    .O_STB(c_o_stb), .O_DATA(c_o_data), .O_ACK(c_o_ack), .O_BUSY(c_o_busy),
    .DBG_STATE(c_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    a_i_stb = 0; a_i_data = 0; a_o_ack = 1;
    b_i_stb = 0; b_i_data = 0; b_o_ack = 1;
    c_i_stb = 0; c_i_data = 0; c_o_ack = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (a_o_stb !== 1'b0 || a_o_data !== 8'h00 || a_o_busy !== 1'b0 || a_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_a: stb=%b data=%h busy=%b st=%0d, want 0 00 0 0",
               a_o_stb, a_o_data, a_o_busy, a_state);
    end
    checks++;
    if (b_o_stb !== 1'b0 || b_o_busy !== 1'b0 || c_o_stb !== 1'b0 || c_o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_bc: b stb/busy=%b%b c stb/busy=%b%b, want 00 00",
               b_o_stb, b_o_busy, c_o_stb, c_o_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Word on DUT A with O_ACK held high except for an optional stall of
  // stall_len cycles while character stall_at is presented.
  task automatic run_word_a(input logic [31:0] w, input int stall_at, input int stall_len,
                            input string name);
    int n;
    a_i_stb = 1; a_i_data = w;
    #1;
    checks++;
    if (a_i_ack !== 1'b1) begin
      errors++;
      $display("FAIL %s_iack: got %b want 1", name, a_i_ack);
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a_i_stb = 0;
      a_i_data = 32'h5A5A5A5A;
      checks++;
      if (a_o_stb !== 1'b1 || a_o_data !== exp_q[k] || a_o_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_char%0d: stb=%b data=%h busy=%b want 1 %h 1",
                 name, k, a_o_stb, a_o_data, a_o_busy, exp_q[k]);
      end
      if (k == stall_at) begin
        a_o_ack = 0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          checks++;
          if (a_o_stb !== 1'b1 || a_o_data !== exp_q[k]) begin
            errors++;
            $display("FAIL %s_stall%0d: stb=%b data=%h want 1 %h",
                     name, s, a_o_stb, a_o_data, exp_q[k]);
          end
        end
        a_o_ack = 1;
      end
    end
    @(negedge clk);
    checks++;
    if (a_o_stb !== 1'b0 || a_o_busy !== 1'b0 || a_state !== 2'd0) begin
      errors++;
      $display("FAIL %s_end: stb=%b busy=%b st=%0d want 0 0 0", name, a_o_stb, a_o_busy, a_state);
    end
  endtask

  task automatic test_basic();
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    run_word_a(32'h1234ABCD, -1, 0, "basic");
  endtask

  task automatic test_backpressure();
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    run_word_a(32'h1234ABCD, 3, 5, "stall");
  endtask

  task automatic test_back_to_back();
    logic [7:0] ch;
    a_i_stb = 1; a_i_data = 32'h0;
    for (int wi = 0; wi < 2; wi++) begin
      #1;
      checks++;
      if (a_i_ack !== 1'b1) begin
        errors++;
        $display("FAIL b2b_iack%0d: got %b want 1", wi, a_i_ack);
      end
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (wi == 0) a_i_data = 32'hFFFFFFFF;
        if (wi == 1 && k == 9) a_i_stb = 0;
        ch = (k == 8) ? 8'h0D : (k == 9) ? 8'h0A : (wi == 0) ? 8'h30 : 8'h46;
        checks++;
        if (a_o_stb !== 1'b1 || a_o_data !== ch || a_i_ack !== 1'b0) begin
          errors++;
          $display("FAIL b2b_w%0d_c%0d: stb=%b data=%h iack=%b want 1 %h 0",
                   wi, k, a_o_stb, a_o_data, a_i_ack, ch);
        end
      end
      @(negedge clk);
      checks++;
      if (a_o_stb !== 1'b0 || a_o_busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap%0d: stb=%b busy=%b want 0 0", wi, a_o_stb, a_o_busy);
      end
    end
  endtask

  task automatic test_short_lower();
    logic [7:0] ch;
    b_i_stb = 1; b_i_data = 32'h000000F7;
    #1;
    checks++;
    if (b_i_ack !== 1'b1) begin
      errors++;
      $display("FAIL lower_iack: got %b want 1", b_i_ack);
    end
    exp_q = '{8'h66, 8'h37, 8'h33, 8'h63};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) b_i_data = 32'hFFFFFF3C;
      if (k == 3) b_i_stb = 0;
      ch = exp_q[k];
      checks++;
      if (b_o_stb !== 1'b1 || b_o_data !== ch || b_i_ack !== 1'b0) begin
        errors++;
        $display("FAIL lower_c%0d: stb=%b data=%h iack=%b want 1 %h 0",
                 k, b_o_stb, b_o_data, b_i_ack, ch);
      end
      if (k == 1) begin
        @(negedge clk);
        checks++;
        if (b_o_stb !== 1'b0 || b_o_busy !== 1'b0 || b_i_ack !== 1'b1) begin
          errors++;
          $display("FAIL lower_idle: stb=%b busy=%b iack=%b want 0 0 1",
                   b_o_stb, b_o_busy, b_i_ack);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (b_o_stb !== 1'b0 || b_o_busy !== 1'b0) begin
      errors++;
      $display("FAIL lower_end: stb=%b busy=%b want 0 0", b_o_stb, b_o_busy);
    end
  endtask

  task automatic test_one_digit();
    c_i_stb = 1; c_i_data = 32'h1234567A;
    exp_q = '{8'h41, 8'h0D, 8'h0A};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      c_i_stb = 0;
      checks++;
      if (c_o_stb !== 1'b1 || c_o_data !== exp_q[k]) begin
        errors++;
        $display("FAIL one_digit_c%0d: stb=%b data=%h want 1 %h", k, c_o_stb, c_o_data, exp_q[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (c_o_stb !== 1'b0 || c_o_busy !== 1'b0) begin
      errors++;
      $display("FAIL one_digit_end: stb=%b busy=%b want 0 0", c_o_stb, c_o_busy);
    end
  endtask

  task automatic test_reset_mid_word();
    a_i_stb = 1; a_i_data = 32'hDEADBEEF;
    exp_q = '{8'h44, 8'h45, 8'h41, 8'h44};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_i_stb = 0;
      checks++;
      if (a_o_data !== exp_q[k]) begin
        errors++;
        $display("FAIL rst_pre_c%0d: data=%h want %h", k, a_o_data, exp_q[k]);
      end
    end
    rst_n = 0;
    #1;
    checks++;
    if (a_o_stb !== 1'b0 || a_o_busy !== 1'b0 || a_o_data !== 8'h00 || a_state !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid: stb=%b busy=%b data=%h st=%0d want 0 0 00 0",
               a_o_stb, a_o_busy, a_o_data, a_state);
    end
    @(negedge clk);
    rst_n = 1;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      checks++;
      if (a_o_stb !== 1'b0 || a_o_busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_after%0d: stb=%b busy=%b want 0 0", s, a_o_stb, a_o_busy);
      end
    end
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    run_word_a(32'h1234ABCD, 8, 2, "recover");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_short_lower();
    test_one_digit();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_tx_hex_fmt.md
Name: serial_tx_hex_fmt

Overview:
- Upstream feeder for the UART transmit byte FIFO.
- Accepts 32-bit words on a strobe/ack handshake and converts each word to ASCII hexadecimal characters, MSB nibble first.
- Optionally appends CR LF after each word.
- Emits one character per transfer on a byte strobe/ack port that connects directly to the transmitter's I_STB/I_DATA/I_ACK.

Parameters:
- DIGITS, 8, number of hex digits emitted per word (1..8); the low DIGITS*4 bits of the word are used.
- EOL_EN, 1, when 1 append 8'h0D then 8'h0A after the last digit; when 0 emit digits only.
- UPPER, 1, when 1 digits A-F are 8'h41-8'h46; when 0 they are 8'h61-8'h66.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- I_STB  in  1  word request.
- I_DATA  in  32  word to format.
- I_ACK  out  1  word accepted this cycle (combinational).
- O_STB  out  1  character valid (registered).
- O_DATA  out  8  ASCII character (registered).
- O_ACK  in  1  character accepted by the downstream byte FIFO; combinational from O_STB on its side.
- O_BUSY  out  1  high from word acceptance until the last character transfers (registered).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While RST_N=0:
  - O_STB=0, O_DATA=8'h00, O_BUSY=0.
  - State IDLE, word register 0, digit counter 0.
  - Reset mid-word discards the remaining characters; no partial EOL is emitted after release.
- States:
  - IDLE: I_ACK = I_STB. On I_ACK:
    - latch I_DATA;
    - digit counter := DIGITS-1;
    - next cycle O_STB=1, O_DATA=char(nibble DIGITS-1), O_BUSY=1;
    - go to HEX.
  - HEX: on O_STB&&O_ACK:
    - if counter≠0: counter-1, O_DATA := char(next lower nibble) next cycle, O_STB stays 1;
    - if counter=0 and EOL_EN: O_DATA := 8'h0D, go to CR;
    - if counter=0 and not EOL_EN: O_STB := 0, O_BUSY := 0, go to IDLE.
  - CR: on O_STB&&O_ACK: O_DATA := 8'h0A, go to LF.
  - LF: on O_STB&&O_ACK: O_STB := 0, O_BUSY := 0, go to IDLE.
- I_ACK is 0 in every state other than IDLE.
  - I_STB arriving in the cycle the last character transfers is not accepted until the next cycle.
  - This gives one bubble cycle between words.
- Latency: character 0 appears on O_STB one cycle after I_ACK.
- Throughput: with O_ACK held high, one character per cycle. A word takes DIGITS+2*EOL_EN cycles plus the one-cycle IDLE gap.
- Backpressure: while O_STB=1 and O_ACK=0, O_DATA, state and counter hold unchanged. The stall duration is unbounded.
- Nibble→ASCII mapping:
  - 0-9 → 8'h30+n;
  - 10-15 → 8'h41+(n-10) when UPPER=1, 8'h61+(n-10) when UPPER=0.
- I_DATA is sampled only on I_ACK. Changes to I_DATA during HEX/CR/LF have no effect.
- O_ACK with O_STB=0 is ignored.
- DIGITS=1: exactly one digit is emitted from bits [3:0]. The counter never underflows.

Test Plan:
- Defaults, I_DATA=32'h1234ABCD, O_ACK=1 → O_DATA sequence 31 32 33 34 41 42 43 44 0D 0A on 10 consecutive cycles. First character one cycle after I_ACK. O_BUSY falls with the 0A transfer.
- Same word, O_ACK low for 5 cycles at the 4th character → O_DATA holds 8'h34 with O_STB=1 throughout. Sequence completes unchanged.
- DIGITS=2, EOL_EN=0, UPPER=0, I_DATA=32'h000000F7 → 66 37, then O_STB=0. I_ACK re-asserts only in IDLE.
- Back-to-back: I_STB held high with words 32'h0 then 32'hFFFFFFFF → "00000000\r\n" then "FFFFFFFF\r\n". Exactly one idle cycle between the LF transfer and the second I_ACK.
- RST_N pulsed low after the 3rd character of 32'hDEADBEEF → O_STB=0 and O_BUSY=0 immediately. After release, no further characters appear until a new I_STB.
- Connected to the UART transmitter, CFG_CLK_DIV=16'd4 → its TxD line serializes "1234ABCD\r\n" in order with no lost bytes.
